sar_seqgen: RTL and testbench
=============================

Name: sar_seqgen

Overview:
- Timing generator for one SAR conversion. Produces the four non-overlapping phase strobes seq_init, seq_samp, seq_comp and seq_update, which feed the clock-gating stage that combines them with the per-side enables.
- Sequence is INIT, then SAMP, then NBITS pairs of COMP/UPDATE, then a one-cycle DONE.
- Phase lengths are programmable and latched at conversion start. It sits between the config/control register block and the clock gate.

Parameters:
- NBITS, 8: number of bit cycles (COMP/UPDATE pairs) per conversion; legal range 2..32.
- LW, 8: width of each phase-length config field.
- IW, $clog2(NBITS): width of bit_idx.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled only in IDLE; begins a conversion.
- cont  in  1  continuous mode; sampled in DONE.
- cfg_init_len  in  LW  INIT phase length in cycles (0 treated as 1).
- cfg_samp_len  in  LW  SAMP phase length (0 treated as 1).
- cfg_comp_len  in  LW  COMP phase length (0 treated as 1).
- cfg_update_len  in  LW  UPDATE phase length (0 treated as 1).
- seq_init  out  1  registered INIT strobe.
- seq_samp  out  1  registered SAMP strobe.
- seq_comp  out  1  registered COMP strobe.
- seq_update  out  1  registered UPDATE strobe.
- bit_idx  out  IW  bit under conversion; NBITS-1 down to 0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset: state IDLE; all seq_* low, busy low, done low, bit_idx = NBITS-1, counters 0. Reset asserted mid-conversion drops every output low immediately, with no completion pulse.
- FSM states: IDLE, INIT, SAMP, COMP, UPDATE, DONE (+ GAP with the optional feature).
- Outputs are a registered decode of the state: exactly one seq_* high in INIT/SAMP/COMP/UPDATE, none in IDLE/DONE/GAP. Strobes are never simultaneous (one-hot or zero).
- Config latch: all four cfg_*_len fields are latched into shadow registers on leaving IDLE and on the DONE→INIT restart. Changes during a conversion have no effect until the next latch.
- Start latency: start=1 in IDLE at edge k puts the FSM in INIT from cycle k+1, so seq_init is high for cycles k+1..k+Linit.
- Phase duration: a down-counter is loaded with max(len,1)-1 on phase entry; the phase advances when the counter reads 0.
- Transitions:
  - INIT→SAMP.
  - SAMP→COMP, with bit_idx = NBITS-1.
  - COMP→UPDATE.
  - UPDATE→COMP with bit_idx-1 if bit_idx≠0; else UPDATE→DONE.
  - DONE→INIT if cont=1 (no IDLE cycle, bit_idx reloads to NBITS-1); else DONE→IDLE.
- bit_idx: constant through each COMP/UPDATE pair; decrements on the UPDATE→COMP edge only; never wraps below 0.
- start while busy is ignored. start held high in IDLE immediately after DONE starts a new conversion on the next edge.
- Conversion length (busy high, no gap) = Linit + Lsamp + NBITS*(Lcomp+Lupdate) + 1.

Optional Feature:
- Macro: SAR_SEQGEN_DEADTIME_EN.
- Defined:
  - A one-cycle GAP state, with all seq_* low, is inserted between every pair of consecutive strobe phases: INIT/SAMP, SAMP/COMP, COMP/UPDATE, UPDATE/COMP.
  - No gap before DONE or after DONE→INIT.
  - busy stays high in GAP and bit_idx holds.
  - Adds 2*NBITS+1 cycles per conversion.
- Undefined: direct phase-to-phase transitions as above; GAP state absent.

Decomposition:
- Package sar_seq_pkg: state enum, the NBITS and LW defaults, and the phase-index constants for INIT/SAMP/COMP/UPDATE.
- One natural sub-module, sar_seq_timer: loadable LW-bit down-counter with a zero flag, instantiated once and shared across phases. The FSM and output decode stay in the top module.

Test Plan:
- Reset: rst_n low, then high; no start → all outputs 0, bit_idx=NBITS-1, busy=0 indefinitely.
- Basic timing (NBITS=4; lens 2,3,1,1; start pulse at cycle 0):
  - seq_init at cycles 1-2, seq_samp at 3-5.
  - comp/update alternate at 6..13 with bit_idx 3,3,2,2,1,1,0,0.
  - done at 14; busy at 1-14.
- Zero length and mid-conversion config: cfg_comp_len=0 behaves as 1 cycle; cfg changes mid-conversion do not alter the current sequence.
- Continuous mode: cont=1 → seq_init asserts the cycle after done, with no idle cycle; start pulses during busy are ignored.
- Reset mid-operation: rst_n asserted during COMP with bit_idx=2 → all outputs low asynchronously, no done pulse; after release, state is IDLE.
- With SAR_SEQGEN_DEADTIME_EN (same setup as basic timing): done at cycle 23; at least one all-low cycle between every pair of strobes.

Source files
------------

// File: rtl/sar_seq_pkg.sv
// Shared types and constants for the SAR phase sequence generator.
// SAR_SEQGEN_DEADTIME_EN adds the GAP state between strobe phases.
package sar_seq_pkg;

    localparam int unsigned NBITS_DEF = 8;
    localparam int unsigned LW_DEF    = 8;

    localparam logic [1:0] PH_INIT   = 2'd0;
    localparam logic [1:0] PH_SAMP   = 2'd1;
    localparam logic [1:0] PH_COMP   = 2'd2;
    localparam logic [1:0] PH_UPDATE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_SAMP   = 3'd2,
        ST_COMP   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
`ifdef SAR_SEQGEN_DEADTIME_EN
        ,
        ST_GAP    = 3'd6
`endif
    } seq_state_e;

    // Map a strobe state onto the index of its phase-length field.
    function automatic logic [1:0] phase_of(input seq_state_e s);
        case (s)
            ST_SAMP:   return PH_SAMP;
            ST_COMP:   return PH_COMP;
            ST_UPDATE: return PH_UPDATE;
            default:   return PH_INIT;
        endcase
    endfunction

endpackage

// File: rtl/sar_seq_timer.sv
// Loadable down-counter shared by all phases; zero_c flags phase end.
module sar_seq_timer #(
    parameter int unsigned LW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [LW-1:0] load_val,
    output logic          zero_c
);

    logic [LW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - LW'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/sar_seqgen.sv
// SAR conversion timing generator: INIT, SAMP, NBITS x (COMP, UPDATE), DONE.
// Define SAR_SEQGEN_DEADTIME_EN to insert a one-cycle GAP between strobe phases.
module sar_seqgen
    import sar_seq_pkg::*;
#(
    parameter int unsigned NBITS = NBITS_DEF,
    parameter int unsigned LW    = LW_DEF,
    parameter int unsigned IW    = $clog2(NBITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          cont,
    input  logic [LW-1:0] cfg_init_len,
    input  logic [LW-1:0] cfg_samp_len,
    input  logic [LW-1:0] cfg_comp_len,
    input  logic [LW-1:0] cfg_update_len,
    output logic          seq_init,
    output logic          seq_samp,
    output logic          seq_comp,
    output logic          seq_update,
    output logic [IW-1:0] bit_idx,
    output logic          busy,
    output logic          done
);

    localparam logic [IW-1:0] TOP_BIT = IW'(NBITS - 1);

    function automatic logic [LW-1:0] len_m1(input logic [LW-1:0] len);
        return (len == '0) ? '0 : len - LW'(1);
    endfunction

    seq_state_e           state_q, state_d, nxt_c;
    logic [IW-1:0]        bit_d;
    logic                 adv_c, latch_c, tmr_ld_c, tmr_zero_c;
    logic [LW-1:0]        tmr_val_c;
    logic [3:0][LW-1:0]   len_q, cfg_c;
    logic [1:0]           ph_c;
`ifdef SAR_SEQGEN_DEADTIME_EN
    seq_state_e           gap_nxt_q, gap_nxt_d;
    logic                 gap_dec_q, gap_dec_d;
`endif

    assign cfg_c = {cfg_update_len, cfg_comp_len, cfg_samp_len, cfg_init_len};

    // Next-state logic; adv_c requests a move to nxt_c (through GAP when enabled).
    always_comb begin
        state_d  = state_q;
        bit_d    = bit_idx;
        adv_c    = 1'b0;
        nxt_c    = ST_IDLE;
        latch_c  = 1'b0;
`ifdef SAR_SEQGEN_DEADTIME_EN
        gap_nxt_d = gap_nxt_q;
        gap_dec_d = gap_dec_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_INIT;
                    latch_c = 1'b1;
                    bit_d   = TOP_BIT;
                end
            end
            ST_INIT: begin
                adv_c = tmr_zero_c;
                nxt_c = ST_SAMP;
            end
            ST_SAMP: begin
                adv_c = tmr_zero_c;
                nxt_c = ST_COMP;
            end
            ST_COMP: begin
                adv_c = tmr_zero_c;
                nxt_c = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (tmr_zero_c) begin
                    if (bit_idx == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        adv_c = 1'b1;
                        nxt_c = ST_COMP;
`ifndef SAR_SEQGEN_DEADTIME_EN
                        bit_d = bit_idx - IW'(1);
`endif
                    end
                end
            end
            ST_DONE: begin
                if (cont) begin
                    state_d = ST_INIT;
                    latch_c = 1'b1;
                    bit_d   = TOP_BIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef SAR_SEQGEN_DEADTIME_EN
            ST_GAP: begin
                state_d = gap_nxt_q;
                if (gap_dec_q) begin
                    bit_d = bit_idx - IW'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (adv_c) begin
`ifdef SAR_SEQGEN_DEADTIME_EN
            state_d   = ST_GAP;
            gap_nxt_d = nxt_c;
            gap_dec_d = (state_q == ST_UPDATE);
`else
            state_d   = nxt_c;
`endif
        end
    end

    // Timer reload on entry to any strobe phase; fresh cfg is used on the latching edge.
    always_comb begin
        ph_c      = phase_of(state_d);
        tmr_ld_c  = (state_d != state_q) &&
                    ((state_d == ST_INIT) || (state_d == ST_SAMP) ||
                     (state_d == ST_COMP) || (state_d == ST_UPDATE));
        tmr_val_c = len_m1(latch_c ? cfg_c[ph_c] : len_q[ph_c]);
    end

    sar_seq_timer #(.LW(LW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_ld_c),
        .load_val (tmr_val_c),
        .zero_c   (tmr_zero_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
        end else if (latch_c) begin
            len_q <= cfg_c;
        end
    end

    // State register with outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            seq_init   <= 1'b0;
            seq_samp   <= 1'b0;
            seq_comp   <= 1'b0;
            seq_update <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bit_idx    <= TOP_BIT;
        end else begin
            state_q    <= state_d;
            seq_init   <= (state_d == ST_INIT);
            seq_samp   <= (state_d == ST_SAMP);
            seq_comp   <= (state_d == ST_COMP);
            seq_update <= (state_d == ST_UPDATE);
            busy       <= (state_d != ST_IDLE);
            done       <= (state_d == ST_DONE);
            bit_idx    <= bit_d;
        end
    end

`ifdef SAR_SEQGEN_DEADTIME_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_nxt_q <= ST_IDLE;
            gap_dec_q <= 1'b0;
        end else begin
            gap_nxt_q <= gap_nxt_d;
            gap_dec_q <= gap_dec_d;
        end
    end
`endif

endmodule

// File: tb/tb_sar_seqgen.sv
// Directed bench for sar_seqgen (NBITS=4); honours SAR_SEQGEN_DEADTIME_EN.
module tb_sar_seqgen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cont;
    logic [7:0] cfg_init_len, cfg_samp_len, cfg_comp_len, cfg_update_len;
    logic       seq_init, seq_samp, seq_comp, seq_update;
    logic [1:0] bit_idx;
    logic       busy, done;

    int checks   = 0;
    int failures = 0;

    sar_seqgen #(.NBITS(4), .LW(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .cont           (cont),
        .cfg_init_len   (cfg_init_len),
        .cfg_samp_len   (cfg_samp_len),
        .cfg_comp_len   (cfg_comp_len),
        .cfg_update_len (cfg_update_len),
        .seq_init       (seq_init),
        .seq_samp       (seq_samp),
        .seq_comp       (seq_comp),
        .seq_update     (seq_update),
        .bit_idx        (bit_idx),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // {init,samp,comp,update,busy,done,bit_idx}
    function automatic logic [7:0] obs();
        return {seq_init, seq_samp, seq_comp, seq_update, busy, done, bit_idx};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int li, input int ls, input int lc, input int lu);
        cfg_init_len   = 8'(li);
        cfg_samp_len   = 8'(ls);
        cfg_comp_len   = 8'(lc);
        cfg_update_len = 8'(lu);
    endtask

    task automatic phase(input string tag, input logic [3:0] strb, input logic [1:0] idx, input int n);
        int len;
        len = (n == 0) ? 1 : n;
        for (int i = 0; i < len; i++) begin
            check(tag, {24'd0, obs()}, {24'd0, strb, 2'b10, idx});
            tick();
        end
    endtask

    task automatic gap(input logic [1:0] idx);
`ifdef SAR_SEQGEN_DEADTIME_EN
        check("gap", {24'd0, obs()}, {24'd0, 4'b0000, 2'b10, idx});
        tick();
`else
        idx = idx;
`endif
    endtask

    // Checks a whole conversion from its first INIT cycle through the DONE cycle.
    // disturb: during SAMP, retune cfg to 3,1,0,2 and assert start (both must be ignored).
    task automatic run_conv(input int li, input int ls, input int lc, input int lu, input bit disturb);
        phase("init", 4'b1000, 2'd3, li);
        gap(2'd3);
        if (disturb) begin
            set_cfg(3, 1, 0, 2);
            start = 1'b1;
        end
        phase("samp", 4'b0100, 2'd3, ls);
        start = 1'b0;
        gap(2'd3);
        for (int b = 3; b >= 0; b--) begin
            phase("comp", 4'b0010, 2'(b), lc);
            gap(2'(b));
            phase("update", 4'b0001, 2'(b), lu);
            if (b != 0) gap(2'(b));
        end
        check("done", {24'd0, obs()}, {24'd0, 4'b0000, 2'b11, 2'd0});
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        cont  = 1'b0;
        set_cfg(2, 3, 1, 1);
        #12;
        check("reset_vals", {24'd0, obs()}, 32'h03);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_after_reset", {24'd0, obs()}, 32'h03);
        end

        // Basic timing: lens 2,3,1,1.
        start = 1'b1;
        tick();
        start = 1'b0;
        run_conv(2, 3, 1, 1, 1'b0);
        tick();
        check("idle_after_done", {26'd0, obs()[7:2]}, 32'h0);

        // Zero comp length with a mid-conversion config change and start pulse.
        set_cfg(1, 2, 0, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_conv(1, 2, 1, 3, 1'b1);
        start = 1'b1;
        tick();
        check("idle_gap_before_restart", {26'd0, obs()[7:2]}, 32'h0);
        tick();
        start = 1'b0;
        run_conv(3, 1, 1, 2, 1'b0);
        tick();
        check("idle_after_conv3", {26'd0, obs()[7:2]}, 32'h0);

        // Continuous mode: restart straight into INIT with newly latched lengths.
        set_cfg(1, 1, 1, 2);
        cont  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_conv(1, 1, 1, 2, 1'b1);
        tick();
        cont = 1'b0;
        run_conv(3, 1, 1, 2, 1'b0);
        tick();
        check("idle_after_cont", {26'd0, obs()[7:2]}, 32'h0);

        // Asynchronous reset while in COMP with bit_idx=2.
        set_cfg(1, 1, 2, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !(seq_comp && bit_idx == 2'd2); i++) tick();
        check("reach_comp_bit2", {29'd0, seq_comp, bit_idx}, {29'd0, 1'b1, 2'd2});
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {24'd0, obs()}, 32'h03);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_after_mid_reset", {24'd0, obs()}, 32'h03);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
